// File: rtl/sram_arb_pkg.sv
// Shared constants and types for the two-requester 64x128 SRAM arbiter.
package sram_arb_pkg;

  localparam int AW = 6;
  localparam int DW = 128;
  localparam int BW = DW / 8;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
  } sram_req_t;

  typedef enum logic {ST_INIT, ST_RUN} arb_state_e;

endpackage

// File: rtl/sram64x128_arb_if.sv
// Requester-side bus of the SRAM arbiter: request payload, ready handshake, read return.
interface sram64x128_arb_if;
  import sram_arb_pkg::*;

  logic          req;
  logic          ready;
  logic          we;
  logic [AW-1:0] addr;
  logic [BW-1:0] be;
  logic [DW-1:0] wdata;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, be, wdata, input ready, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output ready, rvalid, rdata);

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the preferred requester and moves only on a grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  // ptr_q=0 prefers requester 0; after a grant the other requester becomes preferred.
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (&req_i) gnt_o = ptr_q ? 2'b10 : 2'b01;
      else        gnt_o = req_i;
    end
    ptr_d = ptr_q;
    if (|gnt_o) ptr_d = gnt_o[0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sram64x128_arb.sv
// Round-robin sequencer for one single-port 64x128 byte-writable SRAM shared by two requesters.
// Define SRAM_ARB_INIT_EN to zero-fill the whole array after reset before accepting requests.
module sram64x128_arb
  import sram_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  sram64x128_arb_if.slave  m0,
  sram64x128_arb_if.slave  m1,
  output logic             init_done,
  output logic             sram_cs,
  output logic             sram_we,
  output logic [AW-1:0]    sram_a,
  output logic [BW-1:0]    sram_byte,
  output logic [DW-1:0]    sram_di,
  input  logic [DW-1:0]    sram_do
);

  sram_req_t  req0, req1, sel;
  logic [1:0] gnt;
  logic [1:0] rv_q, rv_d;
  logic       run;

`ifdef SRAM_ARB_INIT_EN
  arb_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + AW'(1);
      if (&cnt_q) state_d = ST_RUN;
    end
  end

  assign run = (state_q == ST_RUN);
`else
  assign run = 1'b1;
`endif

  assign init_done = run;

  rr_arb2 u_arb (
    .clk   (clk),
    .rstn  (rstn),
    .en_i  (run),
    .req_i ({m1.req, m0.req}),
    .gnt_o (gnt)
  );

  assign m0.ready = gnt[0];
  assign m1.ready = gnt[1];

  // Macro drive follows the granted requester; reads never assert byte enables.
  always_comb begin
    req0      = '{we: m0.we, addr: m0.addr, be: m0.be, wdata: m0.wdata};
    req1      = '{we: m1.we, addr: m1.addr, be: m1.be, wdata: m1.wdata};
    sel       = gnt[1] ? req1 : req0;
    sram_cs   = |gnt;
    sram_we   = sel.we;
    sram_a    = sel.addr;
    sram_byte = sel.we ? sel.be : '0;
    sram_di   = sel.wdata;
`ifdef SRAM_ARB_INIT_EN
    if (!run) begin
      sram_cs   = 1'b1;
      sram_we   = 1'b1;
      sram_a    = cnt_q;
      sram_byte = '1;
      sram_di   = '0;
    end
`endif
  end

  // The macro returns data one cycle after CS; remember which requester owns it.
  assign rv_d = gnt & {~m1.we, ~m0.we};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rv_q <= 2'b00;
    else       rv_q <= rv_d;
  end

  assign m0.rvalid = rv_q[0];
  assign m1.rvalid = rv_q[1];
  assign m0.rdata  = sram_do;
  assign m1.rdata  = sram_do;

endmodule
